// File: rtl/uart_seq_pkg.sv
// Shared types and constants for the UART transmit sequencer.
package uart_seq_pkg;

    localparam int unsigned ByteW = 8;

    typedef enum logic [1:0] {
        SqIdle   = 2'd0,
        SqStrobe = 2'd1,
        SqWait   = 2'd2,
        SqGap    = 2'd3
    } sq_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through head, flush and occupancy level.
module byte_fifo
    import uart_seq_pkg::*;
#(
    parameter int unsigned Depth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [ByteW-1:0]       data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [ByteW-1:0]       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] level_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [ByteW-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q;
    logic [AddrW-1:0] rd_ptr_q;
    logic [AddrW:0]   count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (AddrW + 1)'(Depth));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push coinciding with flush is dropped; full is the registered occupancy.
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Feeds queued bytes to a UART transmitter: one active-low strobe per byte,
// hold the byte until tx_complete, then an optional idle gap.
module uart_tx_sequencer
    import uart_seq_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                   sourceClk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ByteW-1:0]       wr_data,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   busy,
    output logic                   drained,
    output logic                   tx_en,
    output logic [ByteW-1:0]       tx_byte,
    input  logic                   tx_complete
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLoad = (GAP_CYCLES > 0) ? GapW'(GAP_CYCLES - 1) : '0;

    sq_state_e        state_q, state_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic [ByteW-1:0] tx_byte_q, tx_byte_d;
    logic             overflow_q;
    logic             drained_q, drained_d;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ByteW-1:0] fifo_head;

    byte_fifo #(
        .Depth(DEPTH)
    ) u_fifo (
        .clk_i  (sourceClk),
        .rst_i  (reset),
        .push_i (wr_en),
        .data_i (wr_data),
        .pop_i  (pop),
        .flush_i(flush),
        .head_o (fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .level_o(level)
    );

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        tx_byte_d = tx_byte_q;
        pop       = 1'b0;
        unique case (state_q)
            SqIdle: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    tx_byte_d = fifo_head;
                    state_d   = SqStrobe;
                end
            end
            SqStrobe: state_d = SqWait;
            SqWait: begin
                if (tx_complete) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = SqGap;
                        gap_d   = GapLoad;
                    end else begin
                        state_d = SqIdle;
                    end
                end
            end
            SqGap: begin
                if (gap_q == '0) state_d = SqIdle;
                else gap_d = gap_q - 1'b1;
            end
            default: state_d = SqIdle;
        endcase
    end

    // A push in the completing cycle means more work is coming, so no drain pulse.
    assign drained_d = (state_q == SqWait) && tx_complete && fifo_empty && !wr_en;

    always_ff @(posedge sourceClk) begin
        if (reset) begin
            state_q    <= SqIdle;
            gap_q      <= '0;
            tx_byte_q  <= '0;
            overflow_q <= 1'b0;
            drained_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            tx_byte_q  <= tx_byte_d;
            overflow_q <= overflow_q | (wr_en & fifo_full);
            drained_q  <= drained_d;
        end
    end

    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = overflow_q;
    assign drained  = drained_q;
    assign busy     = (state_q != SqIdle) || !fifo_empty;
    assign tx_en    = (state_q != SqStrobe);
    assign tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Two sequencer instances (16 deep / no gap, 4 deep / 4-cycle gap) checked every
// cycle against a timestamp-based queue model.
module tb_uart_tx_sequencer;

    localparam int NumDut = 2;
    localparam int DepthA = 16;
    localparam int GapA   = 0;
    localparam int DepthB = 4;
    localparam int GapB   = 4;
    localparam int Never  = 32'h3fff_ffff;

    logic       sourceClk = 1'b0;
    logic       reset     = 1'b1;
    logic       wr_en     = 1'b0;
    logic       flush     = 1'b0;
    logic [7:0] wr_data   = 8'h00;
    logic       tx_complete [NumDut];

    logic       full     [NumDut];
    logic       empty    [NumDut];
    logic       overflow [NumDut];
    logic       busy     [NumDut];
    logic       drained  [NumDut];
    logic       tx_en    [NumDut];
    logic [7:0] tx_byte  [NumDut];
    logic [4:0] level_a;
    logic [2:0] level_b;

    always #5 sourceClk = ~sourceClk;

    uart_tx_sequencer #(
        .DEPTH     (DepthA),
        .GAP_CYCLES(GapA)
    ) dut_a (
        .sourceClk  (sourceClk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .flush      (flush),
        .full       (full[0]),
        .empty      (empty[0]),
        .level      (level_a),
        .overflow   (overflow[0]),
        .busy       (busy[0]),
        .drained    (drained[0]),
        .tx_en      (tx_en[0]),
        .tx_byte    (tx_byte[0]),
        .tx_complete(tx_complete[0])
    );

    uart_tx_sequencer #(
        .DEPTH     (DepthB),
        .GAP_CYCLES(GapB)
    ) dut_b (
        .sourceClk  (sourceClk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .flush      (flush),
        .full       (full[1]),
        .empty      (empty[1]),
        .level      (level_b),
        .overflow   (overflow[1]),
        .busy       (busy[1]),
        .drained    (drained[1]),
        .tx_en      (tx_en[1]),
        .tx_byte    (tx_byte[1]),
        .tx_complete(tx_complete[1])
    );

    // Model: byte queue plus timestamps of the next strobe, return to idle and drain pulse.
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    bit         spur_on = 1'b0;
    logic [7:0] mq [NumDut][$];
    int         idle_from  [NumDut];
    int         strobe_cyc [NumDut];
    int         drain_cyc  [NumDut];
    int         done_at    [NumDut];
    bit         ovf_m      [NumDut];
    logic [7:0] cur_m      [NumDut];

    function automatic int depth_of(input int i);
        return (i == 0) ? DepthA : DepthB;
    endfunction

    function automatic int gap_of(input int i);
        return (i == 0) ? GapA : GapB;
    endfunction

    task automatic chk(input int i, input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL dut%0d %s at cycle %0d: got %0h, expected %0h", i, tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NumDut; i++) begin
            logic [31:0] lvl;
            int sz;
            sz  = mq[i].size();
            lvl = (i == 0) ? 32'(level_a) : 32'(level_b);
            chk(i, "level", lvl, 32'(sz));
            chk(i, "empty", 32'(empty[i]), 32'(sz == 0));
            chk(i, "full", 32'(full[i]), 32'(sz == depth_of(i)));
            chk(i, "overflow", 32'(overflow[i]), 32'(ovf_m[i]));
            chk(i, "busy", 32'(busy[i]), 32'((cyc < idle_from[i]) || (sz != 0)));
            chk(i, "drained", 32'(drained[i]), 32'(cyc == drain_cyc[i]));
            chk(i, "tx_en", 32'(tx_en[i]), 32'(cyc != strobe_cyc[i]));
            chk(i, "tx_byte", 32'(tx_byte[i]), 32'(cur_m[i]));
        end
    endtask

    // Advance the model across the clock edge ending cycle cyc.
    task automatic model_step();
        for (int i = 0; i < NumDut; i++) begin
            int sz0;
            sz0 = mq[i].size();
            if (reset) begin
                mq[i].delete();
                idle_from[i]  = cyc + 1;
                strobe_cyc[i] = -100;
                drain_cyc[i]  = -100;
                done_at[i]    = -100;
                ovf_m[i]      = 1'b0;
                cur_m[i]      = 8'h00;
            end else begin
                if (cyc >= idle_from[i] && sz0 > 0) begin
                    cur_m[i]      = mq[i].pop_front();
                    strobe_cyc[i] = cyc + 1;
                    idle_from[i]  = Never;
                end else if (tx_complete[i] && idle_from[i] == Never && cyc > strobe_cyc[i]) begin
                    idle_from[i] = cyc + 1 + gap_of(i);
                    if (sz0 == 0 && !wr_en) drain_cyc[i] = cyc + 1;
                end
                if (wr_en && sz0 == depth_of(i)) ovf_m[i] = 1'b1;
                if (flush) mq[i].delete();
                else if (wr_en && sz0 < depth_of(i)) mq[i].push_back(wr_data);
            end
        end
    endtask

    task automatic drive(input bit w, input logic [7:0] d, input bit f, input bit r);
        @(negedge sourceClk);
        check_all();
        wr_en   = w;
        wr_data = d;
        flush   = f;
        reset   = r;
        for (int i = 0; i < NumDut; i++) begin
            if (cyc == strobe_cyc[i]) done_at[i] = cyc + int'($urandom_range(2, 6));
            tx_complete[i] = (cyc == done_at[i]) || (spur_on && $urandom_range(0, 15) == 0);
        end
        @(posedge sourceClk);
        model_step();
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < NumDut; i++) tx_complete[i] = 1'b0;
        @(posedge sourceClk);
        model_step();
        cyc++;
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        idle(3);

        drive(1'b1, 8'h55, 1'b0, 1'b0);
        idle(20);

        for (int k = 0; k < 3; k++) drive(1'b1, 8'h41 + 8'(k), 1'b0, 1'b0);
        idle(60);

        // Overfill while the first byte is in flight.
        drive(1'b1, 8'h10, 1'b0, 1'b0);
        idle(3);
        for (int k = 0; k < 18; k++) drive(1'b1, 8'h80 + 8'(k), 1'b0, 1'b0);
        idle(200);

        for (int k = 0; k < 6; k++) drive(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0);
        idle(1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        idle(60);

        spur_on = 1'b1;
        for (int k = 0; k < 4; k++) drive(1'b1, 8'hC0 + 8'(k), 1'b0, 1'b0);
        idle(4);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        idle(3);
        drive(1'b1, 8'h99, 1'b0, 1'b0);
        idle(40);

        repeat (2500) begin
            drive($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 63) == 0,
                  $urandom_range(0, 255) == 0);
        end
        idle(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
